// File: rtl/encoded_request_decoder_if.sv
// encoded_request_decoder_if: encoded request, acknowledge and status bundle between the upstream encoder, the decoder and the consumer
interface encoded_request_decoder_if #(
  parameter int CODE_W = 2,
  parameter int CNT_W = 8
);
  localparam int N = 2 ** CODE_W;
  logic in_valid;
  logic [CODE_W-1:0] in_code;
  logic in_ready;
  logic [N-1:0] ack;
  logic clr_flags;
  logic [N-1:0] pend;
  logic [N-1:0] last_onehot;
  logic [CNT_W-1:0] evt_count;
  logic [N-1:0] timeout_flag;
  modport master (
    output in_valid, in_code, ack, clr_flags,
    input in_ready, pend, last_onehot, evt_count, timeout_flag
  );
  modport slave (
    input in_valid, in_code, ack, clr_flags,
    output in_ready, pend, last_onehot, evt_count, timeout_flag
  );
endinterface

// File: rtl/encoded_request_decoder.sv
// encoded_request_decoder: re-expands an encoded request into per-line pending flags released by ack or timeout
module encoded_request_decoder #(
  parameter int CODE_W = 2,
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  encoded_request_decoder_if.slave bus
);
  localparam int N = 2 ** CODE_W;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [N-1:0] r_pend, r_last, r_flag;
  logic [CNT_W-1:0] r_cnt;
  logic [TW-1:0] r_tmr [N];
  logic w_acc;
  logic [N-1:0] w_sel, w_exp, w_pend_nxt, w_last_nxt, w_flag_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [TW-1:0] w_tmr_nxt [N];
  // state register: per-line pending/timer plus shared status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_last <= '0;
      r_flag <= '0;
      r_cnt <= '0;
      for (int i = 0; i < N; i++) r_tmr[i] <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_last <= w_last_nxt;
      r_flag <= w_flag_nxt;
      r_cnt <= w_cnt_nxt;
      for (int i = 0; i < N; i++) r_tmr[i] <= w_tmr_nxt[i];
    end
  end
  // next state: an accept only targets an idle line, so an ack on that line is moot; ack beats expiry, expiry beats clear
  always_comb begin
    w_acc = bus.in_valid & ~r_pend[bus.in_code];
    w_sel = w_acc ? N'(1) << bus.in_code : '0;
    w_exp = '0;
    for (int i = 0; i < N; i++) begin
      w_exp[i] = TIMEOUT > 0 && r_pend[i] && !bus.ack[i] && r_tmr[i] == TW'(TIMEOUT - 1);
      w_tmr_nxt[i] = (TIMEOUT > 0 && r_pend[i] && !bus.ack[i] && !w_exp[i]) ? r_tmr[i] + 1'b1 : '0;
    end
    w_pend_nxt = (r_pend & ~bus.ack & ~w_exp) | w_sel;
    w_last_nxt = w_acc ? w_sel : r_last;
    w_cnt_nxt = bus.clr_flags ? CNT_W'(w_acc) : (w_acc && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    w_flag_nxt = (bus.clr_flags ? '0 : r_flag) | w_exp;
  end
  // outputs: ready depends only on registered pend, never on ack
  always_comb begin
    bus.in_ready = ~r_pend[bus.in_code];
    bus.pend = r_pend;
    bus.last_onehot = r_last;
    bus.evt_count = r_cnt;
    bus.timeout_flag = r_flag;
  end
endmodule

// File: tb/tb_encoded_request_decoder.sv
// tb_encoded_request_decoder: vector table plus directed timeout, saturation and reset sequences
module tb_encoded_request_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  encoded_request_decoder_if #(.CODE_W(2), .CNT_W(8)) bus ();
  encoded_request_decoder #(.CODE_W(2), .TIMEOUT(15), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic v;
    logic [1:0] c;
    logic [3:0] a;
    logic clr;
    logic rdy;
    logic [3:0] pend;
    logic [3:0] last;
    logic [7:0] cnt;
    logic [3:0] flag;
  } vec_t;
  vec_t tbl [17];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic v, input logic [1:0] c, input logic [3:0] a, input logic clr);
    bus.in_valid = v;
    bus.in_code = c;
    bus.ack = a;
    bus.clr_flags = clr;
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 2'd2, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0100, 8'd1, 4'b0000};
    tbl[1]  = '{1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0100, 8'd1, 4'b0000};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = tbl[1];
    tbl[5]  = tbl[1];
    tbl[6]  = '{1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0100, 8'd1, 4'b0000};
    tbl[7]  = '{1'b1, 2'd2, 4'b0000, 1'b0, 1'b1, 4'b0100, 4'b0100, 8'd2, 4'b0000};
    tbl[8]  = '{1'b0, 2'd0, 4'b0100, 1'b0, 1'b1, 4'b0000, 4'b0100, 8'd2, 4'b0000};
    tbl[9]  = '{1'b1, 2'd0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0001, 8'd3, 4'b0000};
    tbl[10] = '{1'b1, 2'd3, 4'b0000, 1'b0, 1'b1, 4'b1001, 4'b1000, 8'd4, 4'b0000};
    tbl[11] = '{1'b0, 2'd0, 4'b1001, 1'b0, 1'b0, 4'b0000, 4'b1000, 8'd4, 4'b0000};
    tbl[12] = '{1'b1, 2'd1, 4'b0010, 1'b0, 1'b1, 4'b0010, 4'b0010, 8'd5, 4'b0000};
    tbl[13] = '{1'b1, 2'd0, 4'b0010, 1'b0, 1'b1, 4'b0001, 4'b0001, 8'd6, 4'b0000};
    tbl[14] = '{1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0001, 8'd0, 4'b0000};
    tbl[15] = '{1'b1, 2'd3, 4'b0000, 1'b1, 1'b1, 4'b1000, 4'b1000, 8'd1, 4'b0000};
    tbl[16] = '{1'b0, 2'd3, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b1000, 8'd1, 4'b0000};
    drive(1'b0, 2'd0, 4'b0000, 1'b0);
    #2;
    chk("rst_pend", 32'(bus.pend), 32'h0);
    chk("rst_last", 32'(bus.last_onehot), 32'h0);
    chk("rst_cnt", 32'(bus.evt_count), 32'h0);
    chk("rst_flag", 32'(bus.timeout_flag), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].v, tbl[k].c, tbl[k].a, tbl[k].clr);
      #1;
      chk($sformatf("v%0d_ready", k), 32'(bus.in_ready), 32'(tbl[k].rdy));
      tick();
      chk($sformatf("v%0d_pend", k), 32'(bus.pend), 32'(tbl[k].pend));
      chk($sformatf("v%0d_last", k), 32'(bus.last_onehot), 32'(tbl[k].last));
      chk($sformatf("v%0d_cnt", k), 32'(bus.evt_count), 32'(tbl[k].cnt));
      chk($sformatf("v%0d_flag", k), 32'(bus.timeout_flag), 32'(tbl[k].flag));
    end
    drive(1'b1, 2'd1, 4'b0000, 1'b0);
    tick();
    drive(1'b0, 2'd1, 4'b0000, 1'b0);
    repeat (14) tick();
    chk("to_pend_e14", 32'(bus.pend), 32'h2);
    chk("to_flag_e14", 32'(bus.timeout_flag), 32'h0);
    tick();
    chk("to_pend_e15", 32'(bus.pend), 32'h0);
    chk("to_flag_e15", 32'(bus.timeout_flag), 32'h2);
    chk("to_cnt", 32'(bus.evt_count), 32'h2);
    drive(1'b1, 2'd2, 4'b0000, 1'b0);
    tick();
    drive(1'b0, 2'd2, 4'b0000, 1'b0);
    repeat (14) tick();
    drive(1'b0, 2'd2, 4'b0000, 1'b1);
    tick();
    chk("toclr_pend", 32'(bus.pend), 32'h0);
    chk("toclr_flag", 32'(bus.timeout_flag), 32'h4);
    chk("toclr_cnt", 32'(bus.evt_count), 32'h0);
    tick();
    drive(1'b0, 2'd2, 4'b0000, 1'b0);
    chk("clr_flag", 32'(bus.timeout_flag), 32'h0);
    drive(1'b1, 2'd1, 4'b0000, 1'b0);
    tick();
    drive(1'b0, 2'd1, 4'b0000, 1'b0);
    repeat (14) tick();
    chk("ackexp_pend_e14", 32'(bus.pend), 32'h2);
    drive(1'b0, 2'd1, 4'b0010, 1'b0);
    tick();
    drive(1'b0, 2'd1, 4'b0000, 1'b0);
    chk("ackexp_pend", 32'(bus.pend), 32'h0);
    chk("ackexp_flag", 32'(bus.timeout_flag), 32'h0);
    for (int p = 0; p < 300; p++) begin
      drive(1'b1, 2'd0, 4'b0000, 1'b0);
      tick();
      drive(1'b0, 2'd0, 4'b0001, 1'b0);
      tick();
    end
    chk("sat_cnt", 32'(bus.evt_count), 32'd255);
    chk("sat_pend", 32'(bus.pend), 32'h0);
    drive(1'b1, 2'd0, 4'b0000, 1'b1);
    tick();
    chk("satclr_cnt", 32'(bus.evt_count), 32'd1);
    chk("satclr_pend", 32'(bus.pend), 32'h1);
    drive(1'b0, 2'd0, 4'b0001, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 4'b0000, 1'b0);
      tick();
    end
    drive(1'b0, 2'd3, 4'b0000, 1'b0);
    chk("pre_rst_pend", 32'(bus.pend), 32'hf);
    chk("pre_rst_cnt", 32'(bus.evt_count), 32'd5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pend", 32'(bus.pend), 32'h0);
    chk("arst_last", 32'(bus.last_onehot), 32'h0);
    chk("arst_cnt", 32'(bus.evt_count), 32'h0);
    chk("arst_flag", 32'(bus.timeout_flag), 32'h0);
    chk("arst_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("post_rst_flag", 32'(bus.timeout_flag), 32'h0);
    chk("post_rst_pend", 32'(bus.pend), 32'h0);
    drive(1'b1, 2'd2, 4'b0000, 1'b0);
    tick();
    chk("post_rst_cnt", 32'(bus.evt_count), 32'd1);
    chk("post_rst_acc", 32'(bus.pend), 32'h4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/encoded_request_decoder.md
Name: encoded_request_decoder

Overview:
- Receiving end of the priority-encoder interface: takes an encoded index plus valid from an upstream encoder and re-expands it to per-line one-hot requests.
- Each request is held pending until the downstream consumer acknowledges it, or until a timeout expires.
- Provides ready/valid backpressure, a registered one-hot of the last accepted code, a saturating event counter and sticky per-line timeout flags.

Parameters:
- CODE_W, 2, width of the encoded index; number of lines N = 2**CODE_W (default 4).
- TIMEOUT, 15, cycles a line may stay pending without ack before auto-clear; 0 disables the timeout.
- CNT_W, 8, width of the saturating accepted-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  encoded request present.
- in_code  input  CODE_W  encoded line index; ignored when in_valid=0.
- in_ready  output  N/A=1  request can be accepted this cycle.
- ack  input  N  per-line acknowledge from the consumer.
- clr_flags  input  1  synchronous clear of evt_count and timeout_flag.
- pend  output  N  per-line pending request flags; several bits may be set at once.
- last_onehot  output  N  registered one-hot of the most recently accepted code.
- evt_count  output  CNT_W  saturating count of accepted requests.
- timeout_flag  output  N  sticky per-line timeout indication.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed):
  - pend, last_onehot, evt_count, timeout_flag and all per-line timers go to 0.
  - in_ready = 1 after reset.
- in_ready is combinational: in_ready = ~pend[in_code]. It is defined regardless of in_valid.
- Accept condition: in_valid & in_ready at a rising edge. On that edge:
  - pend[in_code] <= 1.
  - last_onehot <= 1 << in_code.
  - evt_count <= evt_count+1, saturating at 2**CNT_W-1.
  - Latency: visible one cycle after the accepting edge.
- Stall: in_valid=1 with pend[in_code]=1 gives in_ready=0. Nothing changes; upstream holds its code.
- Per-line state machine (i = 0..N-1):
  - IDLE (pend[i]=0) -> PENDING on accept of code i.
  - PENDING -> IDLE on ack[i]=1 at an edge.
  - PENDING -> IDLE on timeout expiry.
  - ack[i] while IDLE is ignored.
- Timer: tmr[i] is 0 on entry to PENDING and increments on each edge while PENDING with ack[i]=0.
  - If TIMEOUT>0 and the line is set at edge E0 with no ack on edges E1..E_TIMEOUT, then at edge E_TIMEOUT: pend[i] <= 0 and timeout_flag[i] <= 1.
- Simultaneous events:
  - ack[i] on the expiry edge: ack wins, no timeout flag.
  - Accept of line i and ack[i] on the same edge: accept requires pend[i]=0, so the ack is ignored and pend[i] <= 1.
  - Accept on line j and ack/timeout on line i≠j in the same edge: both take effect.
  - clr_flags with a timeout on the same edge: flag is set, i.e. set wins over clear.
  - clr_flags with an accept on the same edge: evt_count <= 1.
- clr_flags does not affect pend or last_onehot.
- No combinational path from ack to in_ready within the same cycle; ack acts only at the edge.
- Reset asserted mid-operation: all state is cleared immediately. Pending requests are lost and no flags are set.

Test Plan:
- Reset release; in_valid=1, in_code=2 for one cycle -> next cycle pend=0100, last_onehot=0100, evt_count=1; with in_code=2 held, in_ready=0.
- pend=0100, in_valid=1, in_code=2 held 5 cycles -> in_ready=0 throughout, evt_count stays 1; ack=0100 for one cycle -> pend=0000 and in_ready=1 the next cycle, accepted on the following edge, evt_count=2.
- Codes 0 then 3 on consecutive cycles, no ack -> pend=1001, last_onehot=1000, evt_count=2; ack=1001 -> pend=0000.
- TIMEOUT=15: accept code 1, no ack -> pend[1] clears exactly 15 edges later, timeout_flag=0010. Repeat with ack[1] on the 15th edge -> pend clears, timeout_flag stays 0000. clr_flags -> timeout_flag=0000.
- CNT_W=8: 300 accept/ack pairs -> evt_count=255 and holds. clr_flags with a simultaneous accept -> evt_count=1.
- pend=1111 and timers running; drive rst_n low between clock edges -> all outputs 0 immediately. After release, in_ready=1 and the counts restart from 0.
